// File: rtl/multibank_bram_reader.sv
// Port-B read master for the multi-bank BRAM: sweeps an address range across all banks
// in parallel and streams the concatenated words out through a credit-limited FIFO.
module multibank_bram_reader #(
  parameter int BANKS      = 4,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR       = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDR-1:0]        base_addr,
  input  logic [ADDR:0]          length,
  output logic                   busy,
  output logic                   done,
  output logic [BANKS-1:0]       enb,
  output logic [BANKS*ADDR-1:0]  addrb,
  input  logic [BANKS*WIDTH-1:0] doutb,
  input  logic [BANKS-1:0]       validb,
  output logic [BANKS*WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int DW = BANKS * WIDTH;
  localparam logic [CW:0]     CREDITS  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR:0]   LEN_ONE  = (ADDR + 1)'(1);
  localparam logic [ADDR:0]   LEN_ZERO = (ADDR + 1)'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [ADDR-1:0] ADDR_ONE = ADDR'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR:0]   len_q, len_d;
  logic [ADDR:0]   issued_q, issued_d;
  logic [ADDR:0]   beat_q, beat_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            enb_q, enb_d;
  logic [ADDR-1:0] addrb_q, addrb_d;
  logic            issue_s, push_s, pop_s, last_beat_s;

  // A read may issue only while every in-flight word and every buffered word still fit the FIFO.
  always_comb begin
    issue_s     = (state_q == S_ISSUE) && (issued_q != len_q) &&
                  (({1'b0, outst_q} + {1'b0, count_q}) < CREDITS);
    // Returns with nothing outstanding belong to a run killed by reset.
    push_s      = validb[0] && (outst_q != CNT_ZERO);
    pop_s       = m_axis_tvalid && m_axis_tready;
    last_beat_s = pop_s && (beat_q == (len_q - LEN_ONE));
  end

  // Next-state, counters and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    enb_d    = 1'b0;
    addrb_d  = addrb_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    beat_d   = pop_s ? (beat_q + LEN_ONE) : beat_q;

    case ({issue_s, push_s})
      2'b10:   outst_d = outst_q + CNT_ONE;
      2'b01:   outst_d = outst_q - CNT_ONE;
      default: outst_d = outst_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = length;
          addr_d   = base_addr;
          issued_d = LEN_ZERO;
          beat_d   = LEN_ZERO;
          state_d  = (length == LEN_ZERO) ? S_DONE : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (issue_s) begin
          enb_d    = 1'b1;
          addrb_d  = addr_q;
          addr_d   = addr_q + ADDR_ONE;
          issued_d = issued_q + LEN_ONE;
          state_d  = (issued_q == (len_q - LEN_ONE)) ? S_DRAIN : S_ISSUE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (last_beat_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State, counters, port-B drive and FIFO storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= {ADDR{1'b0}};
      len_q    <= LEN_ZERO;
      issued_q <= LEN_ZERO;
      beat_q   <= LEN_ZERO;
      outst_q  <= CNT_ZERO;
      count_q  <= CNT_ZERO;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enb_q    <= 1'b0;
      addrb_q  <= {ADDR{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      beat_q   <= beat_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      enb_q    <= enb_d;
      addrb_q  <= addrb_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= doutb;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign enb           = {BANKS{enb_q}};
  assign addrb         = {BANKS{addrb_q}};
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != CNT_ZERO);
  assign m_axis_tlast  = m_axis_tvalid && (beat_q == (len_q - LEN_ONE));

  multibank_bram_reader_chk #(
    .BANKS      (BANKS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_chk (
    .clk    (clk),
    .rstn   (rstn),
    .push   (push_s),
    .pop    (pop_s),
    .count  (count_q),
    .validb (validb)
  );
endmodule

// Simulation-only protocol checks: FIFO overflow and disagreeing per-bank valid bits.
module multibank_bram_reader_chk #(
  parameter int BANKS      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input logic             clk,
  input logic             rstn,
  input logic             push,
  input logic             pop,
  input logic [CW-1:0]    count,
  input logic [BANKS-1:0] validb
);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (count == FULL)));

  a_validb_agree: assert property (@(posedge clk) disable iff (!rstn)
    (validb == {BANKS{1'b0}}) || (validb == {BANKS{1'b1}}));
endmodule
